// File: rtl/iso7816_3_t0_tpdu_monitor.sv
// Passive ISO7816-3 T=0 TPDU monitor.
// It watches decoded bytes after ATR and T=0 selection. It tracks the command header (CLA..P3),
// procedure bytes, the data phase and SW1/SW2. It gives direction hints for the next expected byte
// and flags protocol violations and work-waiting-time (WWT) expiry.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   enable_i                atr completed & T=0; low aborts to WAIT_CLA (no error pulse)
//   byte_valid_i            1-cycle strobe, byte_data_i holds a direct-convention byte
//   byte_from_card_i        1 = byte sent by the card, 0 = by the terminal
//   etu_tick_i              1-cycle pulse per etu
//   wwt_limit_i             WWT in etus; 0 disables the timeout
//   wait_card_tx_o          next byte expected from the card
//   wait_term_tx_o          next byte expected from the terminal
//   state_o                 FSM state code (0 WAIT_CLA .. 8 WAIT_SW2)
//   cla_o..p3_o             latched command header
//   sw1_o, sw2_o            latched status words
//   sw_valid_o              pulse when SW2 is captured
//   protocol_error_o        pulse on a protocol violation
//   wwt_timeout_o           pulse on WWT expiry
//   data_count_o            data bytes moved in the current command (saturating)
module iso7816_3_t0_tpdu_monitor #(
  parameter int unsigned CountWidth   = 9,
  parameter int unsigned WwtWidth     = 20,
  parameter bit          LenZeroIs256 = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  input  logic                  byte_from_card_i,
  input  logic                  etu_tick_i,
  input  logic [WwtWidth-1:0]   wwt_limit_i,
  output logic                  wait_card_tx_o,
  output logic                  wait_term_tx_o,
  output logic [3:0]            state_o,
  output logic [7:0]            cla_o,
  output logic [7:0]            ins_o,
  output logic [7:0]            p1_o,
  output logic [7:0]            p2_o,
  output logic [7:0]            p3_o,
  output logic [7:0]            sw1_o,
  output logic [7:0]            sw2_o,
  output logic                  sw_valid_o,
  output logic                  protocol_error_o,
  output logic                  wwt_timeout_o,
  output logic [CountWidth-1:0] data_count_o
);

  typedef enum logic [3:0] {
    StWaitCla  = 4'd0,
    StWaitIns  = 4'd1,
    StWaitP1   = 4'd2,
    StWaitP2   = 4'd3,
    StWaitP3   = 4'd4,
    StWaitProc = 4'd5,
    StDataAll  = 4'd6,
    StDataOne  = 4'd7,
    StWaitSw2  = 4'd8
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            cla_q, cla_d, ins_q, ins_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [7:0]            sw1_q, sw1_d, sw2_q, sw2_d;
  logic                  sw_valid_q, sw_valid_d;
  logic                  proto_err_q, proto_err_d;
  logic                  timeout_q, timeout_d;
  logic [CountWidth-1:0] data_count_q, data_count_d;
  logic [CountWidth-1:0] remaining_q, remaining_d;
  logic                  dir_known_q, dir_known_d;
  logic                  dir_card_q, dir_card_d;
  logic [WwtWidth-1:0]   wwt_q, wwt_d;
  logic [WwtWidth-1:0]   wwt_inc;
  logic [CountWidth-1:0] p3_len;
  logic                  wait_card, wait_term;

  assign wwt_inc = wwt_q + WwtWidth'(1);
  assign p3_len  = CountWidth'(p3_q);

  // Direction hints follow enable_i directly so that they are valid straight out of reset.
  always_comb begin
    wait_card = 1'b0;
    wait_term = 1'b0;
    if (enable_i) begin
      unique case (state_q)
        StWaitCla, StWaitIns, StWaitP1, StWaitP2, StWaitP3: wait_term = 1'b1;
        StWaitProc, StWaitSw2:                             wait_card = 1'b1;
        StDataAll, StDataOne: begin
          wait_card = !dir_known_q || dir_card_q;
          wait_term = !dir_known_q || !dir_card_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    cla_d        = cla_q;
    ins_d        = ins_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    p3_d         = p3_q;
    sw1_d        = sw1_q;
    sw2_d        = sw2_q;
    sw_valid_d   = 1'b0;
    proto_err_d  = 1'b0;
    timeout_d    = 1'b0;
    data_count_d = data_count_q;
    remaining_d  = remaining_q;
    dir_known_d  = dir_known_q;
    dir_card_d   = dir_card_q;
    wwt_d        = wwt_q;

    if (!enable_i) begin
      // Abort: registers visible on the ports keep their values for inspection.
      state_d     = StWaitCla;
      remaining_d = '0;
      dir_known_d = 1'b0;
      wwt_d       = '0;
    end else begin
      if (byte_valid_i) begin
        unique case (state_q)
          StWaitCla, StWaitIns, StWaitP1, StWaitP2, StWaitP3: begin
            if (byte_from_card_i) begin
              proto_err_d = 1'b1;
              state_d     = StWaitCla;
            end else begin
              unique case (state_q)
                StWaitCla: begin cla_d = byte_data_i; state_d = StWaitIns;  end
                StWaitIns: begin ins_d = byte_data_i; state_d = StWaitP1;   end
                StWaitP1:  begin p1_d  = byte_data_i; state_d = StWaitP2;   end
                StWaitP2:  begin p2_d  = byte_data_i; state_d = StWaitP3;   end
                default:   begin p3_d  = byte_data_i; state_d = StWaitProc; end
              endcase
            end
          end
          StWaitProc: begin
            dir_known_d = 1'b0;
            if (!byte_from_card_i) begin
              proto_err_d = 1'b1;
              state_d     = StWaitCla;
            end else if (byte_data_i == 8'h60) begin
              state_d = StWaitProc;
            end else if (byte_data_i == ins_q) begin
              if (p3_q != 8'h00) begin
                remaining_d = p3_len;
                state_d     = StDataAll;
              end else if (LenZeroIs256) begin
                remaining_d = CountWidth'(256);
                state_d     = StDataAll;
              end else begin
                remaining_d = '0;
                state_d     = StWaitProc;
              end
            end else if (byte_data_i == ~ins_q) begin
              remaining_d = CountWidth'(1);
              state_d     = StDataOne;
            end else if (byte_data_i[7:4] == 4'h6 || byte_data_i[7:4] == 4'h9) begin
              sw1_d   = byte_data_i;
              state_d = StWaitSw2;
            end else begin
              proto_err_d = 1'b1;
              state_d     = StWaitCla;
            end
          end
          StDataAll, StDataOne: begin
            if (dir_known_q && (byte_from_card_i != dir_card_q)) begin
              proto_err_d = 1'b1;
              state_d     = StWaitCla;
            end else begin
              dir_known_d = 1'b1;
              dir_card_d  = byte_from_card_i;
              remaining_d = remaining_q - CountWidth'(1);
              if (data_count_q != '1) data_count_d = data_count_q + CountWidth'(1);
              if (state_q == StDataOne || remaining_q == CountWidth'(1)) state_d = StWaitProc;
            end
          end
          StWaitSw2: begin
            if (!byte_from_card_i) begin
              proto_err_d = 1'b1;
            end else begin
              sw2_d      = byte_data_i;
              sw_valid_d = 1'b1;
            end
            state_d = StWaitCla;
          end
          default: state_d = StWaitCla;
        endcase
      end

      // A byte always wins over a coincident tick, so no timeout can meet swValid.
      if (byte_valid_i || state_d != state_q) begin
        wwt_d = '0;
      end else if (etu_tick_i && wait_card && state_q != StWaitCla && wwt_limit_i != '0) begin
        if (wwt_inc == wwt_limit_i) begin
          timeout_d   = 1'b1;
          state_d     = StWaitCla;
          dir_known_d = 1'b0;
          wwt_d       = '0;
        end else begin
          wwt_d = wwt_inc;
        end
      end

      if (state_d == StWaitCla && state_q != StWaitCla) data_count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StWaitCla;
      cla_q        <= '0;
      ins_q        <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      p3_q         <= '0;
      sw1_q        <= '0;
      sw2_q        <= '0;
      sw_valid_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      data_count_q <= '0;
      remaining_q  <= '0;
      dir_known_q  <= 1'b0;
      dir_card_q   <= 1'b0;
      wwt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cla_q        <= cla_d;
      ins_q        <= ins_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      p3_q         <= p3_d;
      sw1_q        <= sw1_d;
      sw2_q        <= sw2_d;
      sw_valid_q   <= sw_valid_d;
      proto_err_q  <= proto_err_d;
      timeout_q    <= timeout_d;
      data_count_q <= data_count_d;
      remaining_q  <= remaining_d;
      dir_known_q  <= dir_known_d;
      dir_card_q   <= dir_card_d;
      wwt_q        <= wwt_d;
    end
  end

  assign wait_card_tx_o   = wait_card;
  assign wait_term_tx_o   = wait_term;
  assign state_o          = state_q;
  assign cla_o            = cla_q;
  assign ins_o            = ins_q;
  assign p1_o             = p1_q;
  assign p2_o             = p2_q;
  assign p3_o             = p3_q;
  assign sw1_o            = sw1_q;
  assign sw2_o            = sw2_q;
  assign sw_valid_o       = sw_valid_q;
  assign protocol_error_o = proto_err_q;
  assign wwt_timeout_o    = timeout_q;
  assign data_count_o     = data_count_q;

endmodule

// File: tb/tb_iso7816_3_t0_tpdu_monitor.sv
// Directed bench for iso7816_3_t0_tpdu_monitor: command cases 2/3, ~INS stepping, 256-byte
// transfer, protocol errors, WWT expiry and aborts.
module tb_iso7816_3_t0_tpdu_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_from_card = 1'b0;
  logic        etu_tick = 1'b0;
  logic [19:0] wwt_limit = '0;
  logic        wait_card, wait_term, sw_valid, proto_err, wwt_to;
  logic [3:0]  state;
  logic [7:0]  cla, ins, p1, p2, p3, sw1, sw2;
  logic [8:0]  data_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_swv = 0;
  int n_perr = 0;
  int n_to = 0;

  iso7816_3_t0_tpdu_monitor dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .byte_valid_i     (byte_valid),
    .byte_data_i      (byte_data),
    .byte_from_card_i (byte_from_card),
    .etu_tick_i       (etu_tick),
    .wwt_limit_i      (wwt_limit),
    .wait_card_tx_o   (wait_card),
    .wait_term_tx_o   (wait_term),
    .state_o          (state),
    .cla_o            (cla),
    .ins_o            (ins),
    .p1_o             (p1),
    .p2_o             (p2),
    .p3_o             (p3),
    .sw1_o            (sw1),
    .sw2_o            (sw2),
    .sw_valid_o       (sw_valid),
    .protocol_error_o (proto_err),
    .wwt_timeout_o    (wwt_to),
    .data_count_o     (data_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sw_valid)  n_swv  <= n_swv + 1;
    if (proto_err) n_perr <= n_perr + 1;
    if (wwt_to)    n_to   <= n_to + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge; outputs are sampled at the next falling edge.
  task automatic send(input logic [7:0] d, input logic card, input logic tick = 1'b0);
    @(negedge clk);
    byte_valid     = 1'b1;
    byte_data      = d;
    byte_from_card = card;
    etu_tick       = tick;
    @(negedge clk);
    byte_valid = 1'b0;
    etu_tick   = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    etu_tick = 1'b1;
    @(negedge clk);
    etu_tick = 1'b0;
  endtask

  task automatic header(input logic [7:0] c, i, a, b, l);
    send(c, 1'b0); send(i, 1'b0); send(a, 1'b0); send(b, 1'b0); send(l, 1'b0);
  endtask

  task automatic idle();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_wait_term", 32'(wait_term), 32'd1);
    chk("reset_wait_card", 32'(wait_card), 32'd0);
    chk("reset_cla", 32'(cla), 32'd0);
    chk("reset_count", 32'(data_count), 32'd0);
    chk("reset_pulses", {29'd0, sw_valid, proto_err, wwt_to}, 32'd0);
    enable = 1'b0;
    #1;
    chk("disabled_wait_term", 32'(wait_term), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Case 2 read
    header(8'hA0, 8'hB0, 8'h00, 8'h00, 8'h04);
    chk("t1_state_proc", 32'(state), 32'd5);
    chk("t1_hdr", {cla, ins, p3, 8'h00}, {8'hA0, 8'hB0, 8'h04, 8'h00});
    chk("t1_wait_proc", {30'd0, wait_card, wait_term}, 32'b10);
    send(8'hB0, 1'b1);
    chk("t1_state_data", 32'(state), 32'd6);
    chk("t1_wait_both", {30'd0, wait_card, wait_term}, 32'b11);
    send(8'h11, 1'b1);
    chk("t1_wait_card_dir", {30'd0, wait_card, wait_term}, 32'b10);
    send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1);
    chk("t1_back_proc", 32'(state), 32'd5);
    chk("t1_count", 32'(data_count), 32'd4);
    send(8'h90, 1'b1);
    chk("t1_sw1", {24'd0, sw1}, 32'h90);
    chk("t1_state_sw2", 32'(state), 32'd8);
    send(8'h00, 1'b1);
    chk("t1_sw_valid", 32'(sw_valid), 32'd1);
    chk("t1_sw2", {24'd0, sw2}, 32'h00);
    chk("t1_state_cla", 32'(state), 32'd0);
    chk("t1_count_cleared", 32'(data_count), 32'd0);
    idle();
    chk("t1_swv_once", 32'(n_swv), 32'd1);
    chk("t1_no_err", 32'(n_perr), 32'd0);

    // Case 3 with NULLs; ticks between NULLs never reach the limit
    wwt_limit = 20'd10;
    header(8'h00, 8'hD6, 8'h00, 8'h00, 8'h02);
    send(8'h60, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    send(8'h60, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("t2_null_stay", 32'(state), 32'd5);
    send(8'hD6, 1'b1);
    send(8'hAA, 1'b0);
    chk("t2_wait_term", {30'd0, wait_card, wait_term}, 32'b01);
    send(8'hBB, 1'b0);
    chk("t2_count", 32'(data_count), 32'd2);
    send(8'h90, 1'b1); send(8'h00, 1'b1);
    idle();
    chk("t2_swv", 32'(n_swv), 32'd2);
    chk("t2_no_timeout", 32'(n_to), 32'd0);
    chk("t2_no_err", 32'(n_perr), 32'd0);

    // ~INS stepping
    header(8'h00, 8'hD6, 8'h00, 8'h00, 8'h02);
    send(8'h29, 1'b1);
    chk("t3_state_one", 32'(state), 32'd7);
    send(8'h01, 1'b0);
    chk("t3_proc_1", 32'(state), 32'd5);
    chk("t3_count_1", 32'(data_count), 32'd1);
    send(8'h29, 1'b1);
    send(8'h02, 1'b0);
    chk("t3_proc_2", 32'(state), 32'd5);
    chk("t3_count_2", 32'(data_count), 32'd2);
    send(8'h90, 1'b1); send(8'h00, 1'b1);
    chk("t3_sw", {16'd0, sw1, sw2}, 32'h9000);

    // P3 = 0 means 256 bytes
    header(8'h00, 8'hB0, 8'h00, 8'h00, 8'h00);
    send(8'hB0, 1'b1);
    for (int i = 0; i < 255; i++) send(8'(i), 1'b1);
    chk("t4_still_data", 32'(state), 32'd6);
    chk("t4_count_255", 32'(data_count), 32'd255);
    send(8'hFF, 1'b1);
    chk("t4_proc", 32'(state), 32'd5);
    chk("t4_count_256", 32'(data_count), 32'd256);
    send(8'h61, 1'b1); send(8'h10, 1'b1);
    chk("t4_sw", {16'd0, sw1, sw2}, 32'h6110);
    idle();
    chk("t4_swv", 32'(n_swv), 32'd4);

    // Protocol errors
    send(8'h00, 1'b0);
    send(8'h11, 1'b1);
    chk("t5_hdr_card_err", 32'(proto_err), 32'd1);
    chk("t5_hdr_state", 32'(state), 32'd0);
    header(8'hA0, 8'hB0, 8'h00, 8'h00, 8'h04);
    send(8'hB0, 1'b1); send(8'h55, 1'b1); send(8'h66, 1'b0);
    chk("t5_dir_err", 32'(proto_err), 32'd1);
    chk("t5_dir_state", 32'(state), 32'd0);
    header(8'hA0, 8'hB0, 8'h00, 8'h00, 8'h04);
    send(8'h12, 1'b1);
    chk("t5_proc_err", 32'(proto_err), 32'd1);
    idle();
    chk("t5_err_count", 32'(n_perr), 32'd3);
    chk("t5_swv_unchanged", 32'(n_swv), 32'd4);

    // WWT expiry on the 10th tick
    header(8'h00, 8'hB0, 8'h00, 8'h00, 8'h04);
    for (int i = 0; i < 9; i++) tick();
    chk("t6_no_to_9", {28'd0, state}, 32'd5);
    tick();
    chk("t6_timeout", 32'(wwt_to), 32'd1);
    chk("t6_to_state", 32'(state), 32'd0);
    // Byte coincident with the 10th tick: no timeout, counter restarts
    header(8'h00, 8'hB0, 8'h00, 8'h00, 8'h04);
    for (int i = 0; i < 9; i++) tick();
    send(8'h60, 1'b1, 1'b1);
    chk("t6_coinc_no_to", 32'(wwt_to), 32'd0);
    chk("t6_coinc_state", 32'(state), 32'd5);
    for (int i = 0; i < 9; i++) tick();
    chk("t6_restart_no_to", 32'(state), 32'd5);
    tick();
    chk("t6_restart_to", 32'(wwt_to), 32'd1);
    idle();
    chk("t6_to_count", 32'(n_to), 32'd2);
    // Enable drop mid-data
    wwt_limit = '0;
    header(8'h00, 8'hB0, 8'h00, 8'h00, 8'h04);
    send(8'hB0, 1'b1); send(8'h01, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("t6_dis_state", 32'(state), 32'd0);
    chk("t6_dis_count_hold", 32'(data_count), 32'd1);
    chk("t6_dis_waits", {30'd0, wait_card, wait_term}, 32'b00);
    send(8'hA5, 1'b0);
    chk("t6_dis_ignored", {24'd0, cla}, 32'h00);
    enable = 1'b1;
    idle();
    chk("t6_dis_no_err", 32'(n_perr), 32'd3);
    // Reset mid-data
    header(8'h00, 8'hB0, 8'h00, 8'h00, 8'h04);
    send(8'hB0, 1'b1); send(8'h01, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_count", 32'(data_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
